ldpc_dvb_enc_ctrl_mb: RTL and testbench
=======================================

Name: ldpc_dvb_enc_ctrl_mb

Overview:
Multi-bank successor of the DVB-S2 encoder main controller. It sequences a frame through two phases: data-cycle reads, then IRA parity-row reads. It serves pBUF_NUM input buffer banks in round-robin order, so the input side can fill several frames ahead. It also handles single-cycle and single-row code configurations correctly, and tags every read with the bank it is serving.

Parameters:
pBUF_NUM, 2, number of input buffer banks (1..4); bank index width cBANK_W = max(1, clog2(pBUF_NUM)).
pCYCLE_W, 8, width of data-cycle index.
pROW_W, 8, width of parity-row index.

Ports:
iclk  in  1  clock.
ireset  in  1  asynchronous reset, active-high.
iclkena  in  1  clock enable; all state and counters advance only when high.
ibuf_full  in  pBUF_NUM  per-bank "frame ready" flags.
iobuf_empty  in  1  output buffer can accept a frame.
obuf_empty  out  1  one-tick pulse: current input bank has been released.
obuf_bank  out  cBANK_W  bank released by obuf_empty.
iused_row  in  pROW_W  parity rows per frame (1..2^pROW_W-1).
icycle_max_num  in  pCYCLE_W  data cycles per frame (1..2^pCYCLE_W-1).
ostart  out  1  registered frame-start pulse.
ip_busy  in  1  parity datapath still busy.
ocycle_read  out  1  data-cycle read strobe.
ocycle_idx  out  pCYCLE_W  data-cycle index.
ocycle_bank  out  cBANK_W  bank being read; valid during all non-WAIT states.
op_read  out  1  parity-row read strobe.
op_sof  out  1  first parity row of the frame.
op_eof  out  1  last parity row of the frame.
op_row_idx  out  pROW_W  parity row index.
obusy  out  1  high in every state except RESET and WAIT.

Behaviour:
- Reset values: state RESET; bank pointer 0. obuf_empty, ostart, ocycle_read, op_read, op_sof, op_eof and obusy are all 0. ocycle_idx = 0, op_row_idx = 0, obuf_bank = 0.
- FSM states and transitions:
  - RESET -> WAIT.
  - WAIT -> INIT when ibuf_full[ptr] and iobuf_empty are both high. Other banks' flags are ignored; there is no skipping.
  - INIT: latches iused_row and icycle_max_num; clears both counters. -> DATA.
  - DATA: ocycle_read=1, ocycle_idx counts 0..icycle_max_num-1, one per enabled tick. -> WAIT_DATA after the tick with index icycle_max_num-1.
  - icycle_max_num=1: exactly one DATA tick, index 0.
  - WAIT_DATA -> DO_P when ip_busy=0.
  - DO_P: op_read=1, op_row_idx counts 0..iused_row-1.
    - op_sof=1 only at row 0; op_eof=1 only at row iused_row-1.
    - iused_row=1: sof and eof are both high in the single tick.
    - -> WAIT_DO_P after the eof tick.
  - WAIT_DO_P -> DONE.
  - DONE: ptr <= (ptr==pBUF_NUM-1) ? 0 : ptr+1. -> WAIT.
- Done-detection uses compare-to-last, not a pre-decremented limit, so limit 1 is legal. A limit of 0 is illegal: it is treated as the maximum count and wraps.
- ostart: registered copy of (state==INIT). It is high during the first DATA tick, gated by iclkena.
- obuf_empty: registered, not gated by iclkena. It is high for exactly one iclk cycle on the first DO_P tick, i.e. after the first parity row's parameters are latched. obuf_bank holds the released ptr value in the same cycle.
- Input changes to iused_row or icycle_max_num after INIT have no effect on the current frame.
- iclkena low freezes every registered output except obuf_empty. obuf_empty is forced to 0 while iclkena is low.
- ireset asserted mid-frame: immediate return to reset values. The bank is not released and ptr returns to 0.

Optional Feature:
Macro LDPC_DVB_ENC_CTRL_ABORT_EN.
- Defined: adds input iabort (1 bit).
  - iabort=1 in INIT, DATA, WAIT_DATA or DO_P goes to DONE on the next enabled tick.
  - If the bank was not yet released, obuf_empty pulses with the current ptr in that cycle. No op_eof is issued, and ptr advances normally.
  - iabort is ignored in WAIT, WAIT_DO_P and DONE.
- Undefined: no iabort port; the behaviour is as above.

Test Plan:
- pBUF_NUM=2, icycle_max_num=5, iused_row=3, ibuf_full=2'b01, iobuf_empty=1 -> ocycle_idx 0..4; then op_row_idx 0,1,2 with sof on 0 and eof on 2; obuf_empty pulse with obuf_bank=0; ptr becomes 1.
- Next frame with ibuf_full=2'b01 -> FSM stays in WAIT; set bit1 -> frame runs with ocycle_bank=1, then ptr wraps to 0.
- icycle_max_num=1, iused_row=1 -> exactly one ocycle_read tick; exactly one op_read tick with op_sof=op_eof=1.
- ip_busy held high 10 cycles after DATA -> FSM waits in WAIT_DATA; op_read rises on the first tick after ip_busy falls.
- iclkena toggled 50% during DO_P with iused_row=4 -> the four rows appear in order with no duplicates; obuf_empty is one cycle wide.
- ireset pulsed during DO_P row 2 -> all outputs return to reset values; obuf_empty not re-pulsed; next frame starts at bank 0. With ABORT_EN, iabort during DATA -> obuf_empty pulse, no op_eof, ptr advances.

Source files
------------

// File: rtl/ldpc_dvb_enc_ctrl_mb_if.sv
// rtl/ldpc_dvb_enc_ctrl_mb_if.sv - buffer/read bus of the multi-bank DVB-S2 LDPC encoder controller
// Carries iabort only when LDPC_DVB_ENC_CTRL_ABORT_EN is defined.
interface ldpc_dvb_enc_ctrl_mb_if #(
  parameter int pBUF_NUM = 2,
  parameter int pCYCLE_W = 8,
  parameter int pROW_W   = 8
);
  localparam int cBANK_W = (pBUF_NUM > 1) ? $clog2(pBUF_NUM) : 1;

  logic [pBUF_NUM-1:0] ibuf_full;
  logic                iobuf_empty;
  logic                obuf_empty;
  logic [cBANK_W-1:0]  obuf_bank;
  logic [pROW_W-1:0]   iused_row;
  logic [pCYCLE_W-1:0] icycle_max_num;
  logic                ostart;
  logic                ip_busy;
  logic                ocycle_read;
  logic [pCYCLE_W-1:0] ocycle_idx;
  logic [cBANK_W-1:0]  ocycle_bank;
  logic                op_read;
  logic                op_sof;
  logic                op_eof;
  logic [pROW_W-1:0]   op_row_idx;
  logic                obusy;
`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
  logic                iabort;
`endif

  modport master (
`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
    input  iabort,
`endif
    input  ibuf_full, iobuf_empty, iused_row, icycle_max_num, ip_busy,
    output obuf_empty, obuf_bank, ostart, ocycle_read, ocycle_idx, ocycle_bank,
    output op_read, op_sof, op_eof, op_row_idx, obusy
  );

  modport slave (
`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
    output iabort,
`endif
    output ibuf_full, iobuf_empty, iused_row, icycle_max_num, ip_busy,
    input  obuf_empty, obuf_bank, ostart, ocycle_read, ocycle_idx, ocycle_bank,
    input  op_read, op_sof, op_eof, op_row_idx, obusy
  );
endinterface

// File: rtl/ldpc_dvb_enc_ctrl_mb.sv
// rtl/ldpc_dvb_enc_ctrl_mb.sv - multi-bank DVB-S2 LDPC encoder main controller (data cycles, then IRA parity rows)
// Define LDPC_DVB_ENC_CTRL_ABORT_EN to add the iabort early-termination path.
module ldpc_dvb_enc_ctrl_mb #(
  parameter int pBUF_NUM = 2,
  parameter int pCYCLE_W = 8,
  parameter int pROW_W   = 8
) (
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   iclkena,
  ldpc_dvb_enc_ctrl_mb_if.master bus
);
  localparam int cBANK_W = (pBUF_NUM > 1) ? $clog2(pBUF_NUM) : 1;

  typedef enum logic [2:0] {
    S_RESET, S_WAIT, S_INIT, S_DATA, S_WAIT_DATA, S_DO_P, S_WAIT_DO_P, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [cBANK_W-1:0]  ptr;
  logic [pCYCLE_W-1:0] cycle_cnt, cycle_max;
  logic [pROW_W-1:0]   row_cnt, row_max;
  logic                cycle_last, row_last;
  logic                abort_go, release_go;
  logic                start_r, buf_empty_r;

  // Compare against limit-1 so a limit of 1 is legal; a limit of 0 wraps to the full count.
  assign cycle_last = (cycle_cnt == cycle_max - pCYCLE_W'(1));
  assign row_last   = (row_cnt == row_max - pROW_W'(1));

`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
  assign abort_go = bus.iabort && (state inside {S_INIT, S_DATA, S_WAIT_DATA, S_DO_P});
`else
  assign abort_go = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    release_go      = 1'b0;
    bus.ocycle_read = 1'b0;
    bus.op_read     = 1'b0;
    bus.op_sof      = 1'b0;
    bus.op_eof      = 1'b0;
    bus.obusy       = 1'b1;
    case (state)
      S_RESET: begin
        bus.obusy = 1'b0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        bus.obusy = 1'b0;
        if (bus.ibuf_full[ptr] && bus.iobuf_empty) state_nxt = S_INIT;
      end
      S_INIT: state_nxt = S_DATA;
      S_DATA: begin
        bus.ocycle_read = 1'b1;
        if (cycle_last) state_nxt = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (!bus.ip_busy) begin
          state_nxt  = S_DO_P;
          release_go = 1'b1;
        end
      end
      S_DO_P: begin
        bus.op_read = 1'b1;
        bus.op_sof  = (row_cnt == '0);
        bus.op_eof  = row_last && !abort_go;
        if (row_last) state_nxt = S_WAIT_DO_P;
      end
      S_WAIT_DO_P: state_nxt = S_DONE;
      S_DONE:      state_nxt = S_WAIT;
      default:     state_nxt = S_RESET;
    endcase
    // An abort before the parity phase still has to hand the bank back.
    if (abort_go) begin
      state_nxt  = S_DONE;
      release_go = (state != S_DO_P);
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state       <= S_RESET;
      ptr         <= '0;
      cycle_cnt   <= '0;
      cycle_max   <= '0;
      row_cnt     <= '0;
      row_max     <= '0;
      start_r     <= 1'b0;
      buf_empty_r <= 1'b0;
    end else begin
      buf_empty_r <= iclkena && release_go;
      if (iclkena) begin
        state   <= state_nxt;
        start_r <= (state == S_INIT);
        case (state)
          S_INIT: begin
            cycle_max <= bus.icycle_max_num;
            row_max   <= bus.iused_row;
            cycle_cnt <= '0;
            row_cnt   <= '0;
          end
          S_DATA:  if (!cycle_last) cycle_cnt <= cycle_cnt + pCYCLE_W'(1);
          S_DO_P:  if (!row_last)   row_cnt   <= row_cnt + pROW_W'(1);
          S_DONE:  ptr <= (ptr == cBANK_W'(pBUF_NUM - 1)) ? '0 : ptr + cBANK_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign bus.ostart      = start_r;
  assign bus.obuf_empty  = buf_empty_r;
  assign bus.obuf_bank   = ptr;
  assign bus.ocycle_bank = ptr;
  assign bus.ocycle_idx  = cycle_cnt;
  assign bus.op_row_idx  = row_cnt;
endmodule

// File: tb/tb_ldpc_dvb_enc_ctrl_mb.sv
// tb/tb_ldpc_dvb_enc_ctrl_mb.sv - scoreboard bench for the multi-bank LDPC encoder controller
// Covers the LDPC_DVB_ENC_CTRL_ABORT_EN path when that macro is defined.
`timescale 1ns/1ps
module tb_ldpc_dvb_enc_ctrl_mb;
  localparam int pBUF_NUM = 2;
  localparam int pCYCLE_W = 8;
  localparam int pROW_W   = 8;

  logic iclk;
  logic ireset;
  logic iclkena;

  ldpc_dvb_enc_ctrl_mb_if #(.pBUF_NUM(pBUF_NUM), .pCYCLE_W(pCYCLE_W), .pROW_W(pROW_W)) bus ();

  ldpc_dvb_enc_ctrl_mb #(.pBUF_NUM(pBUF_NUM), .pCYCLE_W(pCYCLE_W), .pROW_W(pROW_W)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .bus     (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    bit kind;
    int idx;
    int bank;
    bit sof;
    bit eof;
  } exp_t;

  exp_t exp_q[$];
  int   rel_q[$];
  int   checks;
  int   errors;
  int   pulses;
  bit   abort_mode;

  task automatic push_frame(input int bank, input int ncyc, input int nrows);
    exp_t e;
    for (int i = 0; i < ncyc; i++) begin
      e.kind = 1'b0; e.idx = i; e.bank = bank; e.sof = 1'b0; e.eof = 1'b0;
      exp_q.push_back(e);
    end
    for (int r = 0; r < nrows; r++) begin
      e.kind = 1'b1; e.idx = r; e.bank = bank; e.sof = (r == 0); e.eof = (r == nrows - 1);
      exp_q.push_back(e);
    end
    rel_q.push_back(bank);
  endtask

  task automatic run_monitor();
    exp_t        e;
    logic [31:0] act_idx;
    int          rb;
    forever begin
      @(negedge iclk);
      if (!ireset && iclkena && (bus.ocycle_read || bus.op_read)) begin
        checks++;
        act_idx = bus.op_read ? {{(32-pROW_W){1'b0}}, bus.op_row_idx} : {{(32-pCYCLE_W){1'b0}}, bus.ocycle_idx};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: got cycle_read=%0b p_read=%0b idx=%0d, required no read",
                   bus.ocycle_read, bus.op_read, act_idx);
        end else begin
          e = exp_q.pop_front();
          if (bus.op_read !== e.kind || bus.ocycle_read !== !e.kind || act_idx !== e.idx ||
              32'(bus.ocycle_bank) !== e.bank || bus.op_sof !== e.sof || bus.op_eof !== e.eof) begin
            errors++;
            $display("FAIL read_seq: got p_read=%0b idx=%0d bank=%0d sof=%0b eof=%0b, required p_read=%0b idx=%0d bank=%0d sof=%0b eof=%0b",
                     bus.op_read, act_idx, bus.ocycle_bank, bus.op_sof, bus.op_eof, e.kind, e.idx, e.bank, e.sof, e.eof);
          end
        end
      end
      if (!ireset && (bus.ostart || (bus.ocycle_read && bus.ocycle_idx == '0))) begin
        checks++;
        if (bus.ostart !== (bus.ocycle_read && bus.ocycle_idx == '0)) begin
          errors++;
          $display("FAIL ostart: got ostart=%0b at cycle_read=%0b idx=%0d, required high only on first data tick",
                   bus.ostart, bus.ocycle_read, bus.ocycle_idx);
        end
      end
      if (!ireset && bus.obuf_empty) begin
        checks++;
        pulses++;
        if (rel_q.size() == 0) begin
          errors++;
          $display("FAIL release_unexpected: got obuf_empty=1 bank=%0d, required no release", bus.obuf_bank);
        end else begin
          rb = rel_q.pop_front();
          if (32'(bus.obuf_bank) !== rb || (!abort_mode && bus.op_sof !== 1'b1)) begin
            errors++;
            $display("FAIL release: got bank=%0d sof=%0b, required bank=%0d sof=%0b",
                     bus.obuf_bank, bus.op_sof, rb, !abort_mode);
          end
        end
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (bus.obusy !== 1'b1 && n < 100) begin
      @(posedge iclk); #1; n++;
    end
    ok = (bus.obusy === 1'b1);
    bus.ibuf_full = '0;
    @(posedge iclk); #1;
    bus.icycle_max_num = bus.icycle_max_num + 8'd7;
    bus.iused_row      = bus.iused_row + 8'd9;
  endtask

  task automatic wait_end(output bit ok);
    int n = 0;
    while (bus.obusy === 1'b1 && n < 3000) begin
      @(posedge iclk); #1; n++;
    end
    ok = (bus.obusy === 1'b0);
  endtask

  task automatic test_reset();
    ireset = 1'b1; iclkena = 1'b1;
    bus.ibuf_full = '0; bus.iobuf_empty = 1'b1; bus.ip_busy = 1'b0;
    bus.icycle_max_num = 8'd5; bus.iused_row = 8'd3;
`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
    bus.iabort = 1'b0;
`endif
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    checks++;
    if ({bus.obuf_empty, bus.ostart, bus.ocycle_read, bus.op_read, bus.op_sof, bus.op_eof, bus.obusy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got empty,start,cread,pread,sof,eof,busy=%b, required 0000000",
               {bus.obuf_empty, bus.ostart, bus.ocycle_read, bus.op_read, bus.op_sof, bus.op_eof, bus.obusy});
    end
    checks++;
    if (bus.ocycle_idx !== '0 || bus.op_row_idx !== '0 || bus.obuf_bank !== '0 || bus.ocycle_bank !== '0) begin
      errors++;
      $display("FAIL reset_indices: got cidx=%0d row=%0d bbank=%0d cbank=%0d, required all 0",
               bus.ocycle_idx, bus.op_row_idx, bus.obuf_bank, bus.ocycle_bank);
    end
    @(posedge iclk); #1 ireset = 1'b0;
    repeat (5) @(posedge iclk);
    @(negedge iclk);
    checks++;
    if (bus.obusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got obusy=%0b, required 0", bus.obusy);
    end
  endtask

  task automatic test_basic();
    bit ok_s, ok_e;
    pulses = 0;
    bus.icycle_max_num = 8'd5; bus.iused_row = 8'd3;
    push_frame(0, 5, 3);
    bus.ibuf_full = 2'b01;
    wait_start(ok_s);
    wait_end(ok_e);
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!(ok_s && ok_e) || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 1) begin
      errors++;
      $display("FAIL basic_frame: got start=%0b end=%0b pending=%0d rel=%0d pulses=%0d, required 1 1 0 0 1",
               ok_s, ok_e, exp_q.size(), rel_q.size(), pulses);
    end
  endtask

  task automatic test_round_robin();
    bit ok_s, ok_e, stayed;
    stayed = 1'b1;
    bus.ibuf_full = 2'b01;
    repeat (20) begin
      @(posedge iclk); #1;
      if (bus.obusy !== 1'b0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin
      errors++;
      $display("FAIL rr_no_skip: got busy with only bank0 ready at ptr1, required idle");
    end
    pulses = 0;
    bus.icycle_max_num = 8'd4; bus.iused_row = 8'd2;
    push_frame(1, 4, 2);
    bus.ibuf_full = 2'b11;
    wait_start(ok_s);
    wait_end(ok_e);
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!(ok_s && ok_e) || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 1) begin
      errors++;
      $display("FAIL rr_bank1: got start=%0b end=%0b pending=%0d rel=%0d pulses=%0d, required 1 1 0 0 1",
               ok_s, ok_e, exp_q.size(), rel_q.size(), pulses);
    end
  endtask

  task automatic test_single();
    bit ok_s, ok_e;
    pulses = 0;
    bus.icycle_max_num = 8'd1; bus.iused_row = 8'd1;
    push_frame(0, 1, 1);
    bus.ibuf_full = 2'b01;
    wait_start(ok_s);
    wait_end(ok_e);
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!(ok_s && ok_e) || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 1) begin
      errors++;
      $display("FAIL single_frame: got start=%0b end=%0b pending=%0d rel=%0d pulses=%0d, required 1 1 0 0 1",
               ok_s, ok_e, exp_q.size(), rel_q.size(), pulses);
    end
  endtask

  task automatic test_p_busy();
    bit ok_s, ok_e, held;
    int n;
    pulses = 0;
    held = 1'b1;
    bus.icycle_max_num = 8'd3; bus.iused_row = 8'd2;
    push_frame(1, 3, 2);
    bus.ip_busy = 1'b1;
    bus.ibuf_full = 2'b10;
    wait_start(ok_s);
    n = 0;
    while (bus.ocycle_read === 1'b1 && n < 50) begin
      @(posedge iclk); #1; n++;
    end
    repeat (10) begin
      @(posedge iclk); #1;
      if (bus.op_read !== 1'b0 || bus.obusy !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL pbusy_hold: got parity read while ip_busy high, required wait");
    end
    bus.ip_busy = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    checks++;
    if (bus.op_read !== 1'b1 || bus.op_sof !== 1'b1) begin
      errors++;
      $display("FAIL pbusy_release: got op_read=%0b sof=%0b, required 1 1", bus.op_read, bus.op_sof);
    end
    wait_end(ok_e);
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!(ok_s && ok_e) || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 1) begin
      errors++;
      $display("FAIL pbusy_frame: got start=%0b end=%0b pending=%0d rel=%0d pulses=%0d, required 1 1 0 0 1",
               ok_s, ok_e, exp_q.size(), rel_q.size(), pulses);
    end
  endtask

  task automatic test_clkena();
    bit ok_s;
    int n;
    pulses = 0;
    bus.icycle_max_num = 8'd3; bus.iused_row = 8'd4;
    push_frame(0, 3, 4);
    bus.ibuf_full = 2'b01;
    wait_start(ok_s);
    n = 0;
    while (bus.obusy === 1'b1 && n < 3000) begin
      @(posedge iclk); #1;
      iclkena = ~iclkena;
      n++;
    end
    iclkena = 1'b1;
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!ok_s || bus.obusy !== 1'b0 || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 1) begin
      errors++;
      $display("FAIL clkena_frame: got start=%0b busy=%0b pending=%0d rel=%0d pulses=%0d, required 1 0 0 0 1",
               ok_s, bus.obusy, exp_q.size(), rel_q.size(), pulses);
    end
  endtask

  task automatic test_reset_mid();
    bit ok_s, ok_e;
    int n;
    bus.icycle_max_num = 8'd2; bus.iused_row = 8'd4;
    push_frame(1, 2, 4);
    bus.ibuf_full = 2'b10;
    wait_start(ok_s);
    n = 0;
    while (!(bus.op_read === 1'b1 && bus.op_row_idx == 8'd2) && n < 200) begin
      @(negedge iclk); n++;
    end
    #2 ireset = 1'b1;
    #1;
    checks++;
    if ({bus.obuf_empty, bus.ostart, bus.ocycle_read, bus.op_read, bus.op_sof, bus.op_eof, bus.obusy} !== 7'b0 ||
        bus.op_row_idx !== '0 || bus.ocycle_idx !== '0 || bus.obuf_bank !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got strobes=%b row=%0d cidx=%0d bank=%0d, required all 0",
               {bus.obuf_empty, bus.ostart, bus.ocycle_read, bus.op_read, bus.op_sof, bus.op_eof, bus.obusy},
               bus.op_row_idx, bus.ocycle_idx, bus.obuf_bank);
    end
    checks++;
    if (!ok_s || exp_q.size() != 1 || rel_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_progress: got start=%0b pending=%0d rel=%0d, required 1 1 0", ok_s, exp_q.size(), rel_q.size());
    end
    exp_q.delete();
    rel_q.delete();
    pulses = 0;
    repeat (3) @(posedge iclk);
    #1 ireset = 1'b0;
    bus.icycle_max_num = 8'd2; bus.iused_row = 8'd2;
    push_frame(0, 2, 2);
    bus.ibuf_full = 2'b01;
    wait_start(ok_s);
    wait_end(ok_e);
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!(ok_s && ok_e) || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 1) begin
      errors++;
      $display("FAIL midreset_next: got start=%0b end=%0b pending=%0d rel=%0d pulses=%0d, required 1 1 0 0 1",
               ok_s, ok_e, exp_q.size(), rel_q.size(), pulses);
    end
  endtask

`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
  task automatic test_abort();
    bit ok_s, ok_e, ok_s2, ok_e2;
    int n;
    abort_mode = 1'b1;
    pulses = 0;
    bus.icycle_max_num = 8'd6; bus.iused_row = 8'd2;
    push_frame(1, 3, 0);
    bus.ibuf_full = 2'b10;
    wait_start(ok_s);
    n = 0;
    while (!(bus.ocycle_read === 1'b1 && bus.ocycle_idx == 8'd2 && iclkena) && n < 200) begin
      @(negedge iclk); n++;
    end
    bus.iabort = 1'b1;
    @(posedge iclk); #1 bus.iabort = 1'b0;
    wait_end(ok_e);
    repeat (2) @(posedge iclk); #1;
    abort_mode = 1'b0;
    bus.icycle_max_num = 8'd1; bus.iused_row = 8'd1;
    push_frame(0, 1, 1);
    bus.ibuf_full = 2'b01;
    wait_start(ok_s2);
    wait_end(ok_e2);
    repeat (2) @(posedge iclk); #1;
    checks++;
    if (!(ok_s && ok_e && ok_s2 && ok_e2) || exp_q.size() != 0 || rel_q.size() != 0 || pulses != 2) begin
      errors++;
      $display("FAIL abort_frame: got ok=%0b%0b%0b%0b pending=%0d rel=%0d pulses=%0d, required 1111 0 0 2",
               ok_s, ok_e, ok_s2, ok_e2, exp_q.size(), rel_q.size(), pulses);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    abort_mode = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_basic();
    test_round_robin();
    test_single();
    test_p_busy();
    test_clkena();
    test_reset_mid();
`ifdef LDPC_DVB_ENC_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
